// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding and
// counter sizing.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Bits needed to count 0..width inclusive.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, with borrow-out Bout.
module full_subtractor (
   output logic D,
   output logic Bout,
   input  logic A,
   input  logic B,
   input  logic Bin
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first through a single full-subtractor
// cell, with valid/ready handshakes on both operand and result sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int unsigned     CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_q, diff_shift;
   logic [CW-1:0]    cnt_q;
   logic             bw_q, borrow_q, ovf_q;
   logic             a_msb_q, b_msb_q;
   logic             accept, step, last;
   logic             d, bo;

   full_subtractor u_fs (
      .D    (d),
      .Bout (bo),
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .Bin  (bw_q)
   );

   // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps.
   if (WIDTH == 1) begin : g_w1
      assign diff_shift = d;
   end else begin : g_wn
      assign diff_shift = {d, diff_q[WIDTH-1:1]};
   end

   assign last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            step = 1'b1;
            if (last) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bw_q     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
      end else if (accept) begin
         a_sh_q  <= a;
         b_sh_q  <= b;
         bw_q    <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
      end else if (step) begin
         a_sh_q <= a_sh_q >> 1;
         b_sh_q <= b_sh_q >> 1;
         diff_q <= diff_shift;
         bw_q   <= bo;
         cnt_q  <= cnt_q + CW'(1);
         // The last bit produced is the result MSB, so overflow is decided here.
         if (last) begin
            borrow_q <= bo;
            ovf_q    <= (a_msb_q != b_msb_q) && (d != a_msb_q);
         end
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign ovf       = ovf_q;

endmodule
